// File: rtl/cp_pipeline.sv
// Clocked model of a Muller/Sutherland micropipeline: a chain of C-element control bits,
// each gating a capture register, with two-phase or four-phase bundled-data handshakes.
module cp_pipeline #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int PHASE  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_req,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ack,
   output logic                       out_req,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ack,
   output logic [$clog2(DEPTH+1)-1:0] occ
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  c_q;
   logic [DEPTH-1:0]  c_d;
   logic [DEPTH-1:0]  cap_s;
   logic [DEPTH+1:0]  ext_s;
   logic [DATA_W-1:0] d_q    [DEPTH];
   logic [DATA_W-1:0] d_d    [DEPTH];
   logic [DATA_W-1:0] dsrc_s [DEPTH];
   logic [OCC_W-1:0]  occ_s;

   // Control chain with both environment signals: ext_s[i] is c[i-1], ext_s[i+2] is c[i+1]
   always_comb begin
      ext_s = {out_ack, c_q, in_req};
   end

   // C-element update: a stage follows its predecessor once the successor has moved on
   always_comb begin
      c_d = c_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ext_s[i] == ~ext_s[i+2]) begin
            c_d[i] = ext_s[i];
         end else begin
            c_d[i] = c_q[i];
         end
      end
   end

   // Capture strobes: every transition in two-phase, rising edges only in four-phase
   always_comb begin
      cap_s = '0;
      if (PHASE == 4) begin
         cap_s = c_d & ~c_q;
      end else begin
         cap_s = c_d ^ c_q;
      end
   end

   // Capture-register next state, each stage fed from its upstream neighbour
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         dsrc_s[i] = (i == 0) ? in_data : d_q[(i == 0) ? 0 : i-1];
         d_d[i]    = cap_s[i] ? dsrc_s[i] : d_q[i];
      end
   end

   // Occupancy: one per stage whose control bit differs from its successor's
   always_comb begin
      occ_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_s = occ_s + OCC_W'(ext_s[i+1] ^ ext_s[i+2]);
      end
   end

   // Pipeline state registers; reset drops every token at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         c_q <= c_d;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign in_ack   = c_q[0];
   assign out_req  = c_q[DEPTH-1];
   assign out_data = d_q[DEPTH-1];
   assign occ      = occ_s;

endmodule

// File: tb/tb_cp_pipeline.sv
// Scoreboard bench for cp_pipeline: a two-phase and a four-phase instance (DEPTH=4),
// expected tokens queued by the producers and checked by independent monitors.
module tb_cp_pipeline;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_req2 = 1'b0, out_ack2 = 1'b0, in_ack2, out_req2;
   logic [7:0] in_data2 = 8'h00, out_data2;
   logic [2:0] occ2;
   logic       in_req4 = 1'b0, out_ack4 = 1'b0, in_ack4, out_req4;
   logic [7:0] in_data4 = 8'h00, out_data4;
   logic [2:0] occ4;

   int         total = 0;
   int         bad = 0;
   int         delivered2 = 0;
   logic       auto2 = 1'b0;
   logic [7:0] q2[$];
   logic [7:0] q4[$];

   always #5 clk = ~clk;

   cp_pipeline #(.DATA_W(8), .DEPTH(4), .PHASE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_req(in_req2), .in_data(in_data2), .in_ack(in_ack2),
      .out_req(out_req2), .out_data(out_data2), .out_ack(out_ack2), .occ(occ2));

   cp_pipeline #(.DATA_W(8), .DEPTH(4), .PHASE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_req(in_req4), .in_data(in_data4), .in_ack(in_ack4),
      .out_req(out_req4), .out_data(out_data4), .out_ack(out_ack4), .occ(occ4));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: sig = (in_ack2 === in_req2);
         1: sig = in_ack4;
         2: sig = out_req4;
         3: sig = (out_req2 !== out_ack2);
         default: sig = 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic val, input string nm);
      int n = 0;
      while (sig(sel) !== val && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(sig(sel)), 32'(val));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      auto2 = 1'b0;
      in_req2 = 1'b0; out_ack2 = 1'b0; in_data2 = 8'h00;
      in_req4 = 1'b0; out_ack4 = 1'b0; in_data4 = 8'h00;
      q2.delete();
      q4.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send2(input logic [7:0] v);
      wait_for(0, 1'b1, "send2_ack_wait");
      @(negedge clk);
      in_data2 = v;
      in_req2 = ~in_req2;
      q2.push_back(v);
   endtask

   task automatic send4(input logic [7:0] v);
      wait_for(1, 1'b0, "send4_idle_wait");
      @(negedge clk);
      in_data4 = v;
      in_req4 = 1'b1;
      q4.push_back(v);
      wait_for(1, 1'b1, "send4_ack_rise");
      in_req4 = 1'b0;
      wait_for(1, 1'b0, "send4_ack_fall");
   endtask

   task automatic drain4();
      wait_for(2, 1'b1, "drain4_req_rise");
      out_ack4 = 1'b1;
      wait_for(2, 1'b0, "drain4_req_fall");
      out_ack4 = 1'b0;
   endtask

   // Two-phase monitor: every out_req transition presents the next queued token
   initial begin : mon2
      logic last2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last2 = 1'b0;
         end else if (out_req2 !== last2) begin
            last2 = out_req2;
            chk("mon2_token_expected", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
               chk("mon2_data", 32'(out_data2), 32'(q2.pop_front()));
               delivered2++;
            end
         end
      end
   end

   // Four-phase monitor: rising out_req presents a token, falling must leave the data alone
   initial begin : mon4
      logic       last4 = 1'b0;
      logic [7:0] lastd4 = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last4 = 1'b0;
            lastd4 = 8'h00;
         end else if (out_req4 !== last4) begin
            last4 = out_req4;
            if (out_req4) begin
               chk("mon4_token_expected", 32'(q4.size() > 0), 32'd1);
               if (q4.size() > 0) begin
                  lastd4 = q4.pop_front();
                  chk("mon4_data", 32'(out_data4), 32'(lastd4));
               end
            end else begin
               chk("mon4_rtz_data_hold", 32'(out_data4), 32'(lastd4));
            end
         end
      end
   end

   // Auto consumer for the streaming test: acknowledges each two-phase event
   initial begin : consumer2
      forever begin
         @(negedge clk);
         if (auto2 && rst_n && (out_req2 !== out_ack2)) begin
            @(negedge clk);
            out_ack2 = out_req2;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int d0;

      // reset and idle
      do_reset();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle2", {20'd0, in_ack2, out_req2, out_data2, occ2}, 32'd0);
         chk("idle4", {20'd0, in_ack4, out_req4, out_data4, occ4}, 32'd0);
      end

      // single token latency and occupancy
      @(negedge clk);
      in_data2 = 8'hA5; in_req2 = 1'b1; q2.push_back(8'hA5);
      @(negedge clk);
      chk("single_in_ack_1cyc", 32'(in_ack2), 32'd1);
      repeat (2) @(negedge clk);
      chk("single_out_req_3cyc", 32'(out_req2), 32'd0);
      @(negedge clk);
      chk("single_out_req_4cyc", 32'(out_req2), 32'd1);
      chk("single_out_data", 32'(out_data2), 32'hA5);
      chk("single_occ", 32'(occ2), 32'd1);
      out_ack2 = 1'b1;
      #1;
      chk("single_occ_after_ack", 32'(occ2), 32'd0);
      repeat (2) @(negedge clk);
      chk("single_queue_empty", 32'(q2.size()), 32'd0);

      // two-phase stall: four tokens fill, fifth waits
      do_reset();
      send2(8'h11); send2(8'h22); send2(8'h33); send2(8'h44);
      repeat (8) @(negedge clk);
      chk("stall2_occ_full", 32'(occ2), 32'd4);
      chk("stall2_in_ack", 32'(in_ack2), 32'd0);
      send2(8'h55);
      repeat (8) @(negedge clk);
      chk("stall2_fifth_blocked", 32'(in_ack2), 32'd0);
      chk("stall2_occ_still_full", 32'(occ2), 32'd4);
      for (int k = 0; k < 5; k++) begin
         wait_for(3, 1'b1, "drain2_present");
         out_ack2 = ~out_ack2;
      end
      repeat (3) @(negedge clk);
      chk("stall2_drained", 32'(q2.size()), 32'd0);
      chk("stall2_fifth_accepted", 32'(in_ack2 === in_req2), 32'd1);

      // four-phase stall: capacity of two tokens
      do_reset();
      send4(8'h01); send4(8'h02);
      repeat (8) @(negedge clk);
      chk("stall4_occ", 32'(occ4), 32'd4);
      in_data4 = 8'h03; in_req4 = 1'b1; q4.push_back(8'h03);
      repeat (8) @(negedge clk);
      chk("stall4_third_blocked", 32'(in_ack4), 32'd0);
      drain4();
      drain4();
      wait_for(1, 1'b1, "stall4_third_ack");
      in_req4 = 1'b0;
      wait_for(1, 1'b0, "stall4_third_rtz");
      drain4();
      repeat (3) @(negedge clk);
      chk("stall4_drained", 32'(q4.size()), 32'd0);

      // throughput: 16 random words with an auto-acking consumer
      do_reset();
      auto2 = 1'b1;
      d0 = delivered2;
      for (int k = 0; k < 16; k++) begin
         send2(8'($urandom_range(0, 255)));
      end
      for (int n = 0; n < 300 && q2.size() > 0; n++) @(negedge clk);
      chk("thru_queue_empty", 32'(q2.size()), 32'd0);
      chk("thru_delivered", 32'(delivered2 - d0), 32'd16);

      // reset mid-stream with three tokens held
      do_reset();
      send2(8'hC1); send2(8'hC2); send2(8'hC3);
      repeat (8) @(negedge clk);
      chk("midrst_occ3", 32'(occ2), 32'd3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_outputs", {20'd0, in_ack2, out_req2, out_data2, occ2}, 32'd0);
      q2.delete();
      in_req2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_data2 = 8'h5A; in_req2 = 1'b1; q2.push_back(8'h5A);
      repeat (3) @(negedge clk);
      chk("midrst_out_req_3cyc", 32'(out_req2), 32'd0);
      @(negedge clk);
      chk("midrst_out_req_4cyc", 32'(out_req2), 32'd1);
      chk("midrst_out_data", 32'(out_data2), 32'h5A);
      repeat (2) @(negedge clk);
      chk("midrst_queue_empty", 32'(q2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
